// File: rtl/lagarto_dcache_req_arbiter_pkg.sv
// Shared types for the Lagarto dcache request arbiter: cache geometry, FSM states,
// and the packed load/store holding-register layouts.
package drac_pkg;
  localparam int DCACHE_INDEX_WIDTH = 12;
  localparam int DCACHE_TAG_WIDTH   = 44;

  typedef enum logic [2:0] {
    IDLE, LD_REQ, LD_TAG, LD_WAIT, ST_REQ, DRAIN
  } arb_state_t;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] index;
    logic [DCACHE_TAG_WIDTH-1:0]   tag;
    logic [7:0]                    be;
    logic [1:0]                    size;
  } ld_hold_t;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] index;
    logic [DCACHE_TAG_WIDTH-1:0]   tag;
    logic [63:0]                   wdata;
    logic [7:0]                    be;
    logic [1:0]                    size;
  } st_hold_t;
endpackage

// File: rtl/lagarto_dcache_req_arbiter.sv
// Merges the core's load and store channels onto the single L1 dcache port, sequencing
// VIPT index/tag phases, load kill/drain, and store anti-starvation.
module lagarto_dcache_req_arbiter
  import drac_pkg::*;
#(
  parameter int          INDEX_W      = DCACHE_INDEX_WIDTH,
  parameter int          TAG_W        = DCACHE_TAG_WIDTH,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [INDEX_W-1:0] ld_index_i,
  input  logic [TAG_W-1:0]   ld_tag_i,
  input  logic [7:0]         ld_be_i,
  input  logic [1:0]         ld_size_i,
  input  logic               ld_valid_i,
  input  logic               ld_kill_i,
  input  logic [INDEX_W-1:0] st_index_i,
  input  logic [TAG_W-1:0]   st_tag_i,
  input  logic [63:0]        st_wdata_i,
  input  logic [7:0]         st_be_i,
  input  logic [1:0]         st_size_i,
  input  logic               st_valid_i,
  output logic               ld_ready_o,
  output logic               st_ready_o,
  output logic [INDEX_W-1:0] req_index_o,
  output logic [TAG_W-1:0]   req_tag_o,
  output logic [63:0]        req_wdata_o,
  output logic               req_valid_o,
  output logic               req_we_o,
  output logic [7:0]         req_be_o,
  output logic [1:0]         req_size_o,
  output logic               req_tag_valid_o,
  output logic               req_kill_o,
  input  logic               gnt_i,
  input  logic               rvalid_i,
  input  logic [63:0]        rdata_i,
  output logic               ld_resp_valid_o,
  output logic [63:0]        ld_resp_data_o,
  output logic               st_done_o,
  output logic               busy_o
);
  arb_state_t  state, state_nxt;
  ld_hold_t    ld_q;
  st_hold_t    st_q;
  logic        ld_full, st_full;
  logic [2:0]  starve_cnt;
  logic [63:0] rdata_q;
  logic        resp_q, done_q, kill_q;

  logic ld_take, st_take, in_ld, kill, ld_avail, st_avail, ld_first, ld_clr, st_clr;

  assign ld_take  = ld_valid_i & ~ld_full;
  assign st_take  = st_valid_i & ~st_full;
  assign in_ld    = state inside {LD_REQ, LD_TAG, LD_WAIT};
  assign kill     = ld_kill_i & in_ld;
  // IDLE looks at the incoming request too, so an accepted op starts on the next cycle.
  assign ld_avail = (ld_full & ~ld_kill_i) | ld_take;
  assign st_avail = st_full | st_take;
  assign ld_first = ld_avail & (~st_avail | ({29'd0, starve_cnt} < STARVE_LIMIT));
  assign ld_clr   = ld_full & ((ld_kill_i & (in_ld | state == IDLE)) |
                               (state == LD_WAIT & rvalid_i));
  assign st_clr   = (state == ST_REQ) & gnt_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ld_first) state_nxt = LD_REQ;
               else if (st_avail) state_nxt = ST_REQ;
      LD_REQ:  if (ld_kill_i) state_nxt = gnt_i ? DRAIN : IDLE;
               else if (gnt_i) state_nxt = LD_TAG;
      LD_TAG:  state_nxt = ld_kill_i ? DRAIN : LD_WAIT;
      LD_WAIT: if (rvalid_i) state_nxt = IDLE;
               else if (ld_kill_i) state_nxt = DRAIN;
      ST_REQ:  if (gnt_i) state_nxt = IDLE;
      DRAIN:   if (rvalid_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      ld_q       <= '0;
      st_q       <= '0;
      ld_full    <= 1'b0;
      st_full    <= 1'b0;
      starve_cnt <= '0;
      rdata_q    <= '0;
      resp_q     <= 1'b0;
      done_q     <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state  <= state_nxt;
      resp_q <= (state == LD_WAIT) & rvalid_i & ~ld_kill_i;
      done_q <= st_clr;
      kill_q <= kill;
      if ((state == LD_WAIT) & rvalid_i) rdata_q <= rdata_i;
      if (ld_clr) ld_full <= 1'b0;
      else if (ld_take) begin
        ld_full <= 1'b1;
        ld_q    <= '{index: ld_index_i, tag: ld_tag_i, be: ld_be_i, size: ld_size_i};
      end
      if (st_clr) st_full <= 1'b0;
      else if (st_take) begin
        st_full <= 1'b1;
        st_q    <= '{index: st_index_i, tag: st_tag_i, wdata: st_wdata_i,
                     be: st_be_i, size: st_size_i};
      end
      // Counts loads that overtook a waiting store; saturates at 7.
      if (!st_full || st_clr) starve_cnt <= '0;
      else if ((state == LD_REQ) && gnt_i && (starve_cnt != 3'd7)) starve_cnt <= starve_cnt + 3'd1;
    end
  end

  always_comb begin
    req_valid_o     = 1'b0;
    req_we_o        = 1'b0;
    req_tag_valid_o = 1'b0;
    req_index_o     = '0;
    req_tag_o       = '0;
    req_wdata_o     = '0;
    req_be_o        = '0;
    req_size_o      = '0;
    case (state)
      LD_REQ: begin
        req_valid_o = 1'b1;
        req_index_o = ld_q.index;
        req_be_o    = ld_q.be;
        req_size_o  = ld_q.size;
      end
      LD_TAG: begin
        req_tag_valid_o = 1'b1;
        req_index_o     = ld_q.index;
        req_tag_o       = ld_q.tag;
        req_be_o        = ld_q.be;
        req_size_o      = ld_q.size;
      end
      ST_REQ: begin
        req_valid_o     = 1'b1;
        req_we_o        = 1'b1;
        req_tag_valid_o = 1'b1;
        req_index_o     = st_q.index;
        req_tag_o       = st_q.tag;
        req_wdata_o     = st_q.wdata;
        req_be_o        = st_q.be;
        req_size_o      = st_q.size;
      end
      default: ;
    endcase
  end

  assign ld_ready_o      = ~ld_full;
  assign st_ready_o      = ~st_full;
  assign req_kill_o      = kill_q;
  assign ld_resp_valid_o = resp_q;
  assign ld_resp_data_o  = rdata_q;
  assign st_done_o       = done_q;
  assign busy_o          = (state != IDLE) | ld_full | st_full;
endmodule
